// File: rtl/tdes_job_scheduler.sv
// Job scheduler in front of a triple-DES core.
// Buffers jobs, dispatches them one at a time to the core, applies ECB/CBC
// chaining around the core and queues results in acceptance order.
module tdes_job_scheduler #(
    parameter int DEPTH   = 4,
    parameter int BLOCK_W = 64
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [BLOCK_W-1:0]      job_data,
    input  logic                    job_encrypt,
    input  logic                    job_chain,
    input  logic                    iv_load,
    input  logic [BLOCK_W-1:0]      iv_data,
    output logic                    core_enable,
    output logic                    core_encr_decr,
    output logic [BLOCK_W-1:0]      core_data,
    input  logic                    core_done,
    input  logic [BLOCK_W-1:0]      core_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [BLOCK_W-1:0]      res_data,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  job_count,
    output logic                    spurious_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

    state_t state;

    // Job FIFO entry layout: {data, encrypt, chain}
    logic [BLOCK_W+1:0] jq_mem [DEPTH];
    logic [AW-1:0]      jq_wr, jq_rd;
    logic [AW:0]        jq_cnt;

    logic [BLOCK_W-1:0] rq_mem [DEPTH];
    logic [AW-1:0]      rq_wr, rq_rd;
    logic [AW:0]        rq_cnt;

    logic [BLOCK_W-1:0] chain_reg;
    logic [BLOCK_W-1:0] cur_data;
    logic               cur_enc;
    logic               cur_chain;
    logic [BLOCK_W-1:0] cap_res;

    logic [BLOCK_W+1:0] head;
    logic [BLOCK_W-1:0] head_data;
    logic               head_enc;
    logic               head_chain;
    logic               job_push;
    logic               dispatch;
    logic               res_full;
    logic               res_push;
    logic               res_pop;
    logic [BLOCK_W-1:0] store_val;

    assign head       = jq_mem[jq_rd];
    assign head_data  = head[BLOCK_W+1:2];
    assign head_enc   = head[1];
    assign head_chain = head[0];

    assign job_ready = (jq_cnt != FULL);
    assign job_push  = job_valid && job_ready;
    assign job_count = jq_cnt;
    assign res_full  = (rq_cnt == FULL);
    // iv_load has priority over dispatch so the new IV is in place for the next job
    assign dispatch  = (state == S_IDLE) && (jq_cnt != '0) && !res_full && !iv_load;
    assign res_push  = (state == S_STORE);
    assign res_valid = (rq_cnt != '0);
    assign res_pop   = res_valid && res_ready;
    assign res_data  = res_valid ? rq_mem[rq_rd] : '0;
    assign busy      = (state != S_IDLE);

    // CBC decrypt unmasks the core output with the previous ciphertext
    assign store_val = (cur_chain && !cur_enc) ? (cap_res ^ chain_reg) : cap_res;

    // Job FIFO storage (contents are don't-care while empty)
    always_ff @(posedge HCLK) begin
        if (job_push)
            jq_mem[jq_wr] <= {job_data, job_encrypt, job_chain};
    end

    // Job FIFO pointers and occupancy
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            jq_wr  <= '0;
            jq_rd  <= '0;
            jq_cnt <= '0;
        end else begin
            if (job_push)
                jq_wr <= jq_wr + PTR_ONE;
            if (dispatch)
                jq_rd <= jq_rd + PTR_ONE;
            if (job_push && !dispatch)
                jq_cnt <= jq_cnt + CNT_ONE;
            else if (!job_push && dispatch)
                jq_cnt <= jq_cnt - CNT_ONE;
        end
    end

    // Result FIFO storage
    always_ff @(posedge HCLK) begin
        if (res_push)
            rq_mem[rq_wr] <= store_val;
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rq_wr  <= '0;
            rq_rd  <= '0;
            rq_cnt <= '0;
        end else begin
            if (res_push)
                rq_wr <= rq_wr + PTR_ONE;
            if (res_pop)
                rq_rd <= rq_rd + PTR_ONE;
            if (res_push && !res_pop)
                rq_cnt <= rq_cnt + CNT_ONE;
            else if (!res_push && res_pop)
                rq_cnt <= rq_cnt - CNT_ONE;
        end
    end

    // Dispatch FSM: issue one job, wait for the core, store and update chaining
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state          <= S_IDLE;
            core_enable    <= 1'b0;
            core_encr_decr <= 1'b0;
            core_data      <= '0;
            chain_reg      <= '0;
            cur_data       <= '0;
            cur_enc        <= 1'b0;
            cur_chain      <= 1'b0;
            cap_res        <= '0;
        end else begin
            core_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iv_load) begin
                        chain_reg <= iv_data;
                    end else if (dispatch) begin
                        cur_data       <= head_data;
                        cur_enc        <= head_enc;
                        cur_chain      <= head_chain;
                        core_data      <= (head_chain && head_enc) ? (head_data ^ chain_reg) : head_data;
                        core_encr_decr <= head_enc;
                        core_enable    <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        cap_res <= core_result;
                        state   <= S_STORE;
                    end
                end
                S_STORE: begin
                    // CBC encrypt chains on ciphertext out, CBC decrypt on ciphertext in
                    if (cur_chain)
                        chain_reg <= cur_enc ? cap_res : cur_data;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for a core completion that arrives with nothing outstanding
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            spurious_done <= 1'b0;
        else if (core_done && (state != S_WAIT))
            spurious_done <= 1'b1;
    end

endmodule

// File: tb/tb_tdes_job_scheduler.sv
// Self-checking bench for tdes_job_scheduler: directed scenarios plus
// randomized traffic, checked against a queue-based reference model.
module tb_tdes_job_scheduler;

    localparam int DEPTH = 4;
    localparam int BW    = 64;

    logic          HCLK;
    logic          HRESET;
    logic          job_valid;
    logic          job_ready;
    logic [BW-1:0] job_data;
    logic          job_encrypt;
    logic          job_chain;
    logic          iv_load;
    logic [BW-1:0] iv_data;
    logic          core_enable;
    logic          core_encr_decr;
    logic [BW-1:0] core_data;
    logic          core_done;
    logic [BW-1:0] core_result;
    logic          res_valid;
    logic          res_ready;
    logic [BW-1:0] res_data;
    logic          busy;
    logic [2:0]    job_count;
    logic          spurious_done;

    tdes_job_scheduler #(.DEPTH(DEPTH), .BLOCK_W(BW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
        .job_encrypt(job_encrypt), .job_chain(job_chain),
        .iv_load(iv_load), .iv_data(iv_data),
        .core_enable(core_enable), .core_encr_decr(core_encr_decr), .core_data(core_data),
        .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .job_count(job_count), .spurious_done(spurious_done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- core model ----------------
    int          cm_mode  = 0;   // 0 scramble, 1 identity, 2 fixed value
    int          cm_delay = 3;
    bit          cm_rand  = 0;
    logic [63:0] cm_fixed = '0;
    int          cm_cnt   = 0;
    logic [63:0] cm_in;
    logic        cm_enc;

    function automatic logic [63:0] cm_fn(input logic [63:0] x, input logic e);
        if (e) return {x[55:0], x[63:56]} ^ 64'h0F1E2D3C4B5A6978;
        return x ^ 64'hC3C3C3C3C3C3C3C3;
    endfunction

    always @(posedge HCLK) begin
        #2;
        core_done = 1'b0;
        if (cm_cnt > 0) begin
            cm_cnt--;
            if (cm_cnt == 0) begin
                core_done = 1'b1;
                case (cm_mode)
                    0:       core_result = cm_fn(cm_in, cm_enc);
                    1:       core_result = cm_in;
                    default: core_result = cm_fixed;
                endcase
            end
        end else if (core_enable) begin
            cm_in  = core_data;
            cm_enc = core_encr_decr;
            cm_cnt = cm_rand ? $urandom_range(1, 6) : cm_delay;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] d;
        logic        e;
        logic        c;
    } job_t;

    job_t        jobq[$];
    job_t        cur_m;
    bit          inflight = 0;
    logic [63:0] exp_in;
    logic [63:0] chain_m = '0;
    logic [63:0] expq[$];
    int          rdyq[$];
    bit          spur_m = 0;
    int          popped_prev = 0;
    int          tick = 0;
    int          nvis;
    logic [63:0] cd_hist[$];
    logic [63:0] res_hist[$];
    int          last_acc_tick = 0;
    int          last_en_tick  = 0;
    logic [63:0] r_m;

    always @(negedge HCLK) begin
        tick++;
        if (HRESET) begin
            jobq.delete();
            expq.delete();
            rdyq.delete();
            inflight    = 0;
            chain_m     = '0;
            spur_m      = 0;
            popped_prev = 0;
            chk("rst_res_valid", res_valid, 0);
            chk("rst_core_enable", core_enable, 0);
            chk("rst_core_data", core_data, 0);
            chk("rst_core_encr_decr", core_encr_decr, 0);
            chk("rst_busy", busy, 0);
            chk("rst_job_count", job_count, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_spurious_done", spurious_done, 0);
        end else begin
            if (core_enable) begin
                chk("dispatch_has_job", (jobq.size() > 0 && !inflight), 1);
                chk("dispatch_room", ((expq.size() + popped_prev) < DEPTH), 1);
                if (jobq.size() > 0 && !inflight) begin
                    cur_m  = jobq.pop_front();
                    exp_in = (cur_m.c && cur_m.e) ? (cur_m.d ^ chain_m) : cur_m.d;
                    chk("core_data", core_data, exp_in);
                    chk("core_encr_decr", core_encr_decr, cur_m.e);
                    inflight     = 1;
                    last_en_tick = tick;
                    cd_hist.push_back(core_data);
                end
            end
            chk("job_count", job_count, jobq.size());
            chk("job_ready", job_ready, (jobq.size() < DEPTH));
            nvis = 0;
            foreach (rdyq[i]) if (rdyq[i] <= tick) nvis++;
            chk("res_valid", res_valid, (nvis > 0));
            if (nvis > 0) chk("res_data", res_data, expq[0]);
            chk("spurious_done", spurious_done, spur_m);
            if (core_done) begin
                if (inflight) begin
                    chk("core_data_held", core_data, exp_in);
                    chk("core_encr_decr_held", core_encr_decr, cur_m.e);
                    r_m = (cur_m.c && !cur_m.e) ? (core_result ^ chain_m) : core_result;
                    if (cur_m.c) chain_m = cur_m.e ? core_result : cur_m.d;
                    expq.push_back(r_m);
                    rdyq.push_back(tick + 2);
                    inflight = 0;
                end else begin
                    spur_m = 1;
                end
            end
            popped_prev = 0;
            if (res_valid && res_ready && nvis > 0) begin
                res_hist.push_back(res_data);
                void'(expq.pop_front());
                void'(rdyq.pop_front());
                popped_prev = 1;
            end
            if (job_valid && job_ready) begin
                jobq.push_back('{d: job_data, e: job_encrypt, c: job_chain});
                last_acc_tick = tick;
            end
            if (iv_load) begin
                chk("iv_load_idle", busy, 0);
                chain_m = iv_data;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic push_job(input logic [63:0] d, input logic e, input logic c);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        job_valid   = 1'b1;
        job_data    = d;
        job_encrypt = e;
        job_chain   = c;
        while (!done && n < 400) begin
            @(negedge HCLK);
            done = job_ready;
            @(posedge HCLK);
            #1;
            n++;
        end
        job_valid = 1'b0;
        chk("push_accepted", done, 1);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        job_valid = 1'b0;
        res_ready = 1'b1;
        while ((jobq.size() != 0 || inflight || expq.size() != 0) && n < 600) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        chk("quiet_reached", (n < 600), 1);
        @(negedge HCLK);
        chk("quiet_busy", busy, 0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic load_iv(input logic [63:0] v);
        iv_load = 1'b1;
        iv_data = v;
        @(posedge HCLK);
        #1;
        iv_load = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [63:0] bp_data [9];
    int          n;

    initial begin
        HRESET      = 1'b1;
        job_valid   = 1'b0;
        job_data    = '0;
        job_encrypt = 1'b0;
        job_chain   = 1'b0;
        iv_load     = 1'b0;
        iv_data     = '0;
        res_ready   = 1'b1;
        core_done   = 1'b0;
        core_result = '0;
        idle(3);
        HRESET = 1'b0;
        idle(2);

        // ECB encrypt, slow core returning a fixed value
        cm_mode  = 2;
        cm_fixed = 64'h85E813540F0AB405;
        cm_delay = 16;
        cd_hist.delete();
        res_hist.delete();
        push_job(64'h0123456789ABCDEF, 1'b1, 1'b0);
        wait_quiet();
        chk("ecb_enable_count", cd_hist.size(), 1);
        chk("ecb_core_data", cd_hist.size() > 0 ? cd_hist[0] : 'x, 64'h0123456789ABCDEF);
        chk("ecb_res_data", res_hist.size() > 0 ? res_hist[0] : 'x, 64'h85E813540F0AB405);
        chk("dispatch_latency", last_en_tick - last_acc_tick, 2);

        // chain register still zero after ECB
        cm_mode  = 1;
        cm_delay = 2;
        cd_hist.delete();
        push_job(64'h5555555555555555, 1'b1, 1'b1);
        wait_quiet();
        chk("ecb_chain_unchanged", cd_hist.size() > 0 ? cd_hist[0] : 'x, 64'h5555555555555555);

        // CBC encrypt, two blocks, identity core
        load_iv(64'h1111111111111111);
        cd_hist.delete();
        res_hist.delete();
        push_job(64'h2222222222222222, 1'b1, 1'b1);
        push_job(64'h3333333333333333, 1'b1, 1'b1);
        wait_quiet();
        chk("cbc_enc_cd0", cd_hist.size() > 0 ? cd_hist[0] : 'x, 64'h3333333333333333);
        chk("cbc_enc_cd1", cd_hist.size() > 1 ? cd_hist[1] : 'x, 64'h0000000000000000);
        chk("cbc_enc_res0", res_hist.size() > 0 ? res_hist[0] : 'x, 64'h3333333333333333);
        chk("cbc_enc_res1", res_hist.size() > 1 ? res_hist[1] : 'x, 64'h0000000000000000);

        // CBC decrypt
        load_iv(64'hFFFFFFFFFFFFFFFF);
        cm_mode  = 2;
        cm_fixed = 64'h00000000000000FF;
        cd_hist.delete();
        res_hist.delete();
        push_job(64'h0F0F0F0F0F0F0F0F, 1'b0, 1'b1);
        wait_quiet();
        chk("cbc_dec_core_data", cd_hist.size() > 0 ? cd_hist[0] : 'x, 64'h0F0F0F0F0F0F0F0F);
        chk("cbc_dec_res", res_hist.size() > 0 ? res_hist[0] : 'x, 64'hFFFFFFFFFFFFFF00);
        cm_mode = 1;
        cd_hist.delete();
        push_job(64'h0, 1'b1, 1'b1);
        wait_quiet();
        chk("cbc_dec_chain", cd_hist.size() > 0 ? cd_hist[0] : 'x, 64'h0F0F0F0F0F0F0F0F);

        // iv_load holds off a queued job and the latest IV is used
        cd_hist.delete();
        job_valid   = 1'b1;
        job_data    = 64'h1234567890ABCDEF;
        job_encrypt = 1'b1;
        job_chain   = 1'b1;
        iv_load     = 1'b1;
        iv_data     = 64'hAAAAAAAAAAAAAAAA;
        @(posedge HCLK);
        #1;
        job_valid = 1'b0;
        iv_data   = 64'h0F0F0F0F00000000;
        @(posedge HCLK);
        #1;
        iv_load = 1'b0;
        wait_quiet();
        chk("iv_block_core_data", cd_hist.size() > 0 ? cd_hist[0] : 'x, 64'h1D3B597790ABCDEF);

        // Backpressure: result FIFO fills, job FIFO fills, then drain in order
        cm_mode  = 0;
        cm_delay = 3;
        res_ready = 1'b0;
        res_hist.delete();
        for (int i = 0; i < 9; i++) bp_data[i] = 64'h0101010101010101 * (i + 1);
        for (int i = 0; i < 8; i++) push_job(bp_data[i], 1'b1, 1'b0);
        job_valid   = 1'b1;
        job_data    = bp_data[8];
        job_encrypt = 1'b1;
        job_chain   = 1'b0;
        idle(60);
        chk("bp_job_count", job_count, 4);
        chk("bp_job_ready", job_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_results_stored", expq.size(), 4);
        res_ready = 1'b1;
        push_job(bp_data[8], 1'b1, 1'b0);
        wait_quiet();
        chk("bp_result_total", res_hist.size(), 9);
        for (int i = 0; i < 9; i++)
            chk("bp_result_order", res_hist.size() > i ? res_hist[i] : 'x, cm_fn(bp_data[i], 1'b1));

        // Reset while waiting on the core, then a late core_done
        cm_mode  = 1;
        cm_delay = 10;
        res_hist.delete();
        push_job(64'hABCDABCDABCDABCD, 1'b1, 1'b0);
        n = 0;
        while (!inflight && n < 20) begin
            idle(1);
            n++;
        end
        chk("rst_job_dispatched", inflight, 1);
        idle(2);
        HRESET = 1'b1;
        idle(2);
        HRESET = 1'b0;
        idle(15);
        chk("rst_spurious_set", spurious_done, 1);
        chk("rst_no_result", res_valid, 0);
        chk("rst_no_result_hist", res_hist.size(), 0);
        cm_delay = 2;
        push_job(64'h7777777777777777, 1'b1, 1'b0);
        wait_quiet();
        chk("rst_next_job", res_hist.size() > 0 ? res_hist[res_hist.size()-1] : 'x, 64'h7777777777777777);
        HRESET = 1'b1;
        idle(2);
        HRESET = 1'b0;
        idle(2);
        chk("rst_spurious_cleared", spurious_done, 0);

        // Randomized traffic
        cm_mode = 0;
        cm_rand = 1;
        for (int it = 0; it < 2000; it++) begin
            job_valid   = ($urandom_range(0, 2) != 0);
            job_data    = {$urandom, $urandom};
            job_encrypt = $urandom_range(0, 1);
            job_chain   = $urandom_range(0, 1);
            res_ready   = ($urandom_range(0, 3) != 0);
            @(posedge HCLK);
            #1;
            if ((it % 250) == 249) begin
                wait_quiet();
                load_iv({$urandom, $urandom});
            end
        end
        wait_quiet();
        chk("end_jobs_empty", jobq.size(), 0);
        chk("end_results_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
